// File: rtl/mips_defs.sv
`default_nettype none
// ============================================================================
// Module   : mips_defs
// Purpose  : Shared multicycle MIPS definitions: FSM states, opcodes, ALUOp codes.
// Revision : 1.0
// ============================================================================
package mips_defs;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTE  = 4'd6,
        S_ALUWB    = 4'd7,
        S_BRANCH   = 4'd8,
        S_ADDIEX   = 4'd9,
        S_ADDIWB   = 4'd10,
        S_JUMP     = 4'd11
    } state_t;

    localparam logic [5:0] c_OP_RTYPE = 6'b000000;
    localparam logic [5:0] c_OP_LW    = 6'b100011;
    localparam logic [5:0] c_OP_SW    = 6'b101011;
    localparam logic [5:0] c_OP_BEQ   = 6'b000100;
    localparam logic [5:0] c_OP_ADDI  = 6'b001000;
    localparam logic [5:0] c_OP_J     = 6'b000010;

    localparam logic [1:0] c_ALUOP_ADD   = 2'b00;
    localparam logic [1:0] c_ALUOP_SUB   = 2'b01;
    localparam logic [1:0] c_ALUOP_FUNCT = 2'b10;

    function automatic logic is_supported(input logic [5:0] op);
        return (op == c_OP_RTYPE) || (op == c_OP_LW) || (op == c_OP_SW) ||
               (op == c_OP_BEQ) || (op == c_OP_ADDI) || (op == c_OP_J);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mc_controller.sv
`default_nettype none
// ============================================================================
// Module   : mc_controller
// Purpose  : Moore control FSM for a multicycle MIPS with optional memory handshake.
// Revision : 1.0
// ============================================================================
module mc_controller #(
    parameter int MEM_HANDSHAKE = 1,
    parameter int CNT_W         = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [5:0]       opcode,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             PCWrite,
    output logic             IorD,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic             MemtoReg,
    output logic             RegDst,
    output logic             RegWrite,
    output logic             ALUSrcA,
    output logic             illegal,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ALUOp,
    output logic [1:0]       PCSource,
    output logic [3:0]       state,
    output logic [CNT_W-1:0] fetch_count
);
    import mips_defs::*;

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_fetch_count;
    logic             w_mem_done;

    assign w_mem_done  = (MEM_HANDSHAKE == 0) || mem_ready;
    assign state       = r_state;
    assign fetch_count = r_fetch_count;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state       <= S_FETCH;
            r_fetch_count <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_FETCH && w_mem_done)
                r_fetch_count <= r_fetch_count + CNT_W'(1);
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_FETCH:    if (w_mem_done) w_next = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    c_OP_LW, c_OP_SW: w_next = S_MEMADR;
                    c_OP_RTYPE:       w_next = S_EXECUTE;
                    c_OP_BEQ:         w_next = S_BRANCH;
                    c_OP_ADDI:        w_next = S_ADDIEX;
                    c_OP_J:           w_next = S_JUMP;
                    default:          w_next = S_FETCH;
                endcase
            end
            S_MEMADR:   w_next = (opcode == c_OP_SW) ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  if (w_mem_done) w_next = S_MEMWB;
            S_MEMWRITE: if (w_mem_done) w_next = S_FETCH;
            S_EXECUTE:  w_next = S_ALUWB;
            S_ADDIEX:   w_next = S_ADDIWB;
            default:    w_next = S_FETCH;
        endcase
    end

    // Outputs are held at zero while reset is asserted, whatever the state.
    always_comb begin
        PCWrite  = 1'b0;
        IorD     = 1'b0;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        IRWrite  = 1'b0;
        MemtoReg = 1'b0;
        RegDst   = 1'b0;
        RegWrite = 1'b0;
        ALUSrcA  = 1'b0;
        illegal  = 1'b0;
        ALUSrcB  = 2'b00;
        ALUOp    = c_ALUOP_ADD;
        PCSource = 2'b00;
        if (reset) begin
            case (r_state)
                S_FETCH: begin
                    MemRead = 1'b1;
                    ALUSrcB = 2'b01;
                    IRWrite = w_mem_done;
                    PCWrite = w_mem_done;
                end
                S_DECODE: begin
                    ALUSrcB = 2'b11;
                    illegal = !is_supported(opcode);
                end
                S_MEMADR: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = 2'b10;
                end
                S_MEMREAD: begin
                    IorD    = 1'b1;
                    MemRead = 1'b1;
                end
                S_MEMWB: begin
                    MemtoReg = 1'b1;
                    RegWrite = 1'b1;
                end
                S_MEMWRITE: begin
                    IorD     = 1'b1;
                    MemWrite = 1'b1;
                end
                S_EXECUTE: begin
                    ALUSrcA = 1'b1;
                    ALUOp   = c_ALUOP_FUNCT;
                end
                S_ALUWB: begin
                    RegDst   = 1'b1;
                    RegWrite = 1'b1;
                end
                S_BRANCH: begin
                    ALUSrcA  = 1'b1;
                    ALUOp    = c_ALUOP_SUB;
                    PCSource = 2'b01;
                    PCWrite  = zero;
                end
                S_ADDIEX: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = 2'b10;
                end
                S_ADDIWB:   RegWrite = 1'b1;
                S_JUMP: begin
                    PCSource = 2'b10;
                    PCWrite  = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mc_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_mc_controller
// Purpose  : Randomized self-checking bench for mc_controller (handshake and no-handshake builds).
// Revision : 1.0
// ============================================================================
module tb_mc_controller;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset_hs, reset_nh;
    logic [5:0] opcode;
    logic       zero, mem_ready;

    logic        hs_pcw, hs_iord, hs_mr, hs_mw, hs_irw, hs_m2r, hs_rd, hs_rw, hs_asa, hs_ill;
    logic [1:0]  hs_asb, hs_aop, hs_pcs;
    logic [3:0]  hs_state;
    logic [31:0] hs_fc;
    logic        nh_pcw, nh_iord, nh_mr, nh_mw, nh_irw, nh_m2r, nh_rd, nh_rw, nh_asa, nh_ill;
    logic [1:0]  nh_asb, nh_aop, nh_pcs;
    logic [3:0]  nh_state;
    logic [3:0]  nh_fc;

    mc_controller #(.MEM_HANDSHAKE(1), .CNT_W(32)) dut_hs (
        .clock(clk), .reset(reset_hs), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .PCWrite(hs_pcw), .IorD(hs_iord), .MemRead(hs_mr), .MemWrite(hs_mw), .IRWrite(hs_irw),
        .MemtoReg(hs_m2r), .RegDst(hs_rd), .RegWrite(hs_rw), .ALUSrcA(hs_asa), .illegal(hs_ill),
        .ALUSrcB(hs_asb), .ALUOp(hs_aop), .PCSource(hs_pcs), .state(hs_state), .fetch_count(hs_fc)
    );

    mc_controller #(.MEM_HANDSHAKE(0), .CNT_W(4)) dut_nh (
        .clock(clk), .reset(reset_nh), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .PCWrite(nh_pcw), .IorD(nh_iord), .MemRead(nh_mr), .MemWrite(nh_mw), .IRWrite(nh_irw),
        .MemtoReg(nh_m2r), .RegDst(nh_rd), .RegWrite(nh_rw), .ALUSrcA(nh_asa), .illegal(nh_ill),
        .ALUSrcB(nh_asb), .ALUOp(nh_aop), .PCSource(nh_pcs), .state(nh_state), .fetch_count(nh_fc)
    );

    // Control vector: [15]PCWrite [14]IorD [13]MemRead [12]MemWrite [11]IRWrite [10]MemtoReg
    // [9]RegDst [8]RegWrite [7]ALUSrcA [6]illegal [5:4]ALUSrcB [3:2]ALUOp [1:0]PCSource
    logic [15:0] hs_ctl, nh_ctl, o_ctl;
    logic [3:0]  o_state;
    logic [31:0] o_fc;
    bit          sel_nh;

    assign hs_ctl = {hs_pcw, hs_iord, hs_mr, hs_mw, hs_irw, hs_m2r, hs_rd, hs_rw, hs_asa, hs_ill,
                     hs_asb, hs_aop, hs_pcs};
    assign nh_ctl = {nh_pcw, nh_iord, nh_mr, nh_mw, nh_irw, nh_m2r, nh_rd, nh_rw, nh_asa, nh_ill,
                     nh_asb, nh_aop, nh_pcs};

    always_comb begin
        o_ctl   = sel_nh ? nh_ctl : hs_ctl;
        o_state = sel_nh ? nh_state : hs_state;
        o_fc    = sel_nh ? {28'd0, nh_fc} : hs_fc;
    end

    int          errors = 0;
    int          checks = 0;
    int unsigned exp_fc;
    int          mw_cycles;
    int          path[$];

    function automatic bit legal_op(input logic [5:0] op);
        return op == OP_R || op == OP_LW || op == OP_SW || op == OP_BEQ || op == OP_ADDI || op == OP_J;
    endfunction

    // Sequence of states an instruction visits, from FETCH up to the return to FETCH.
    function automatic void build_path(input logic [5:0] op);
        case (op)
            OP_LW:   path = '{0, 1, 2, 3, 4};
            OP_SW:   path = '{0, 1, 2, 5};
            OP_R:    path = '{0, 1, 6, 7};
            OP_BEQ:  path = '{0, 1, 8};
            OP_ADDI: path = '{0, 1, 9, 10};
            OP_J:    path = '{0, 1, 11};
            default: path = '{0, 1};
        endcase
    endfunction

    function automatic logic [15:0] exp_ctl(input int st, input bit done, input bit z, input bit ill);
        logic [15:0] c;
        c = '0;
        case (st)
            0:  begin c[13] = 1'b1; c[5:4] = 2'b01; c[15] = done; c[11] = done; end
            1:  begin c[5:4] = 2'b11; c[6] = ill; end
            2:  begin c[7] = 1'b1; c[5:4] = 2'b10; end
            3:  begin c[14] = 1'b1; c[13] = 1'b1; end
            4:  begin c[10] = 1'b1; c[8] = 1'b1; end
            5:  begin c[14] = 1'b1; c[12] = 1'b1; end
            6:  begin c[7] = 1'b1; c[3:2] = 2'b10; end
            7:  begin c[9] = 1'b1; c[8] = 1'b1; end
            8:  begin c[7] = 1'b1; c[3:2] = 2'b01; c[1:0] = 2'b01; c[15] = z; end
            9:  begin c[7] = 1'b1; c[5:4] = 2'b10; end
            10: c[8] = 1'b1;
            11: begin c[1:0] = 2'b10; c[15] = 1'b1; end
            default: ;
        endcase
        return c;
    endfunction

    // Starts and ends at a falling edge; fixed_wait >= 0 forces the memory-state wait length.
    task automatic run_instr(input logic [5:0] op, input bit z, input int fixed_wait);
        logic [15:0] e;
        logic [31:0] efc;
        build_path(op);
        foreach (path[i]) begin
            int st;
            int nwait;
            bit waitable;
            st       = path[i];
            waitable = (st == 0 || st == 3 || st == 5);
            nwait    = 0;
            if (!sel_nh && waitable)
                nwait = (fixed_wait >= 0 && st != 0) ? fixed_wait : int'($urandom_range(0, 2));
            for (int c = 0; c <= nwait; c++) begin
                opcode    = op;
                zero      = z;
                mem_ready = (sel_nh || !waitable) ? 1'($urandom_range(0, 1)) : (c == nwait);
                #1;
                checks++;
                if (o_state !== 4'(st)) begin
                    errors++;
                    $display("FAIL state op=%b got=%0d want=%0d", op, o_state, st);
                end
                e = exp_ctl(st, c == nwait, z, !legal_op(op));
                checks++;
                if (o_ctl !== e) begin
                    errors++;
                    $display("FAIL controls op=%b st=%0d got=%h want=%h", op, st, o_ctl, e);
                end
                efc = sel_nh ? (exp_fc & 32'hF) : exp_fc;
                checks++;
                if (o_fc !== efc) begin
                    errors++;
                    $display("FAIL fetch_count got=%0d want=%0d", o_fc, efc);
                end
                if (o_ctl[12]) mw_cycles++;
                if (st == 0 && c == nwait) exp_fc++;
                @(negedge clk);
            end
        end
    endtask

    task automatic select_dut(input bit nh);
        reset_hs = 1'b0;
        reset_nh = 1'b0;
        @(negedge clk);
        sel_nh = nh;
        if (nh) reset_nh = 1'b1;
        else    reset_hs = 1'b1;
        exp_fc = 0;
    endtask

    task automatic test_reset;
        reset_hs  = 1'b0;
        reset_nh  = 1'b0;
        opcode    = OP_LW;
        zero      = 1'b1;
        mem_ready = 1'b1;
        repeat (3) @(negedge clk);
        for (int n = 0; n < 2; n++) begin
            sel_nh = (n == 1);
            #1;
            checks++;
            if (o_state !== 4'd0 || o_ctl !== 16'h0 || o_fc !== 32'd0) begin
                errors++;
                $display("FAIL reset_values dut=%0d state=%0d ctl=%h fc=%0d want 0/0/0", n, o_state, o_ctl, o_fc);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_lw_no_handshake;
        select_dut(1'b1);
        run_instr(OP_LW, 1'b0, -1);
        checks++;
        if (o_fc !== 32'd1) begin
            errors++;
            $display("FAIL lw_nh_count got=%0d want=1", o_fc);
        end
    endtask

    task automatic test_sw_wait;
        select_dut(1'b0);
        mw_cycles = 0;
        run_instr(OP_SW, 1'b0, 3);
        checks++;
        if (mw_cycles !== 4) begin
            errors++;
            $display("FAIL sw_memwrite_cycles got=%0d want=4", mw_cycles);
        end
        #1;
        checks++;
        if (o_state !== 4'd0) begin
            errors++;
            $display("FAIL sw_return got=%0d want=0", o_state);
        end
    endtask

    task automatic test_branch_illegal;
        run_instr(OP_BEQ, 1'b1, -1);
        run_instr(OP_BEQ, 1'b0, -1);
        run_instr(6'b111111, 1'b1, -1);
        #1;
        checks++;
        if (o_state !== 4'd0) begin
            errors++;
            $display("FAIL illegal_return got=%0d want=0", o_state);
        end
        @(negedge clk);
        run_instr(OP_ADDI, 1'b0, -1);
    endtask

    task automatic test_reset_mid_wait;
        select_dut(1'b0);
        opcode    = OP_LW;
        mem_ready = 1'b1;
        repeat (3) @(negedge clk);
        mem_ready = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if (o_state !== 4'd3 || o_ctl !== 16'h6000) begin
            errors++;
            $display("FAIL memread_wait state=%0d ctl=%h want 3/6000", o_state, o_ctl);
        end
        reset_hs = 1'b0;
        #1;
        checks++;
        if (o_state !== 4'd0 || o_ctl !== 16'h0 || o_fc !== 32'd0) begin
            errors++;
            $display("FAIL async_reset state=%0d ctl=%h fc=%0d want 0/0/0", o_state, o_ctl, o_fc);
        end
        mem_ready = 1'b1;
        @(negedge clk);
        #1;
        checks++;
        if (o_state !== 4'd0 || o_ctl !== 16'h0) begin
            errors++;
            $display("FAIL reset_hold state=%0d ctl=%h want 0/0", o_state, o_ctl);
        end
        @(negedge clk);
        reset_hs = 1'b1;
        exp_fc   = 0;
        run_instr(OP_LW, 1'b0, -1);
    endtask

    task automatic test_wrap;
        select_dut(1'b1);
        repeat (17) run_instr(OP_J, 1'($urandom_range(0, 1)), -1);
        checks++;
        if (o_fc !== 32'd1) begin
            errors++;
            $display("FAIL count_wrap got=%0d want=1", o_fc);
        end
    endtask

    task automatic test_random(input bit nh);
        logic [5:0] ops [6];
        logic [5:0] op;
        ops = '{OP_R, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J};
        select_dut(nh);
        repeat (40) begin
            if ($urandom_range(0, 7) == 0) op = 6'($urandom);
            else                           op = ops[$urandom_range(0, 5)];
            run_instr(op, 1'($urandom_range(0, 1)), -1);
        end
    endtask

    initial begin
        sel_nh = 1'b0;
        exp_fc = 0;
        test_reset();
        test_lw_no_handshake();
        test_sw_wait();
        test_branch_illegal();
        test_reset_mid_wait();
        test_wrap();
        test_random(1'b0);
        test_random(1'b1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired errors=%0d checks=%0d", errors, checks);
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/mc_controller.md
MC_CONTROLLER -- requirements
Module: mc_controller

Interface
Parameters: name, default, meaning.
- REQ-001: The block SHALL have parameter MEM_HANDSHAKE, default 1; 1 = memory states wait for mem_ready, 0 = memory completes in one cycle and mem_ready is ignored.
- REQ-002: The block SHALL have parameter CNT_W, default 32, giving the width of the fetched-instruction counter.

Ports: name, direction, width, meaning.
- REQ-003: The block SHALL have port clock, input, 1, the single clock; all state changes on its rising edge.
- REQ-004: The block SHALL have port reset, input, 1, reset: asynchronous, active-low.
- REQ-005: The block SHALL have ports opcode, input, 6, instruction[31:26]; zero, input, 1, ALU zero flag; mem_ready, input, 1, memory access complete.
- REQ-006: The block SHALL have 1-bit outputs PCWrite, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst, RegWrite, ALUSrcA and illegal; 2-bit outputs ALUSrcB, ALUOp, PCSource; 4-bit output state; CNT_W-bit output fetch_count.

Function
- REQ-007: Moore FSM states SHALL be FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECUTE=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11, and state SHALL present the current encoding.
- REQ-008: Transitions SHALL be: FETCH->DECODE; DECODE->MEMADR (lw 100011, sw 101011), EXECUTE (R 000000), BRANCH (beq 000100), ADDIEX (addi 001000), JUMP (j 000010), else FETCH; MEMADR->MEMREAD (lw) or MEMWRITE (sw); MEMREAD->MEMWB; EXECUTE->ALUWB; ADDIEX->ADDIWB; MEMWB, MEMWRITE, ALUWB, BRANCH, ADDIWB, JUMP->FETCH.
- REQ-009: With MEM_HANDSHAKE=1, FETCH, MEMREAD and MEMWRITE SHALL hold until a cycle with mem_ready=1, then advance; with MEM_HANDSHAKE=0 they SHALL advance after one cycle.
- REQ-010: Output values per state SHALL be (unlisted outputs 0):
  - FETCH: MemRead=1, ALUSrcB=01, IRWrite=PCWrite=1 only in the completing cycle.
  - DECODE: ALUSrcB=11.
  - MEMADR: ALUSrcA=1, ALUSrcB=10.
  - MEMREAD: IorD=1, MemRead=1.
  - MEMWB: MemtoReg=1, RegWrite=1.
  - MEMWRITE: IorD=1, MemWrite=1.
  - EXECUTE: ALUSrcA=1, ALUOp=10.
  - ALUWB: RegDst=1, RegWrite=1.
  - BRANCH: ALUSrcA=1, ALUOp=01, PCSource=01, PCWrite=zero.
  - ADDIEX: ALUSrcA=1, ALUSrcB=10.
  - ADDIWB: RegWrite=1.
  - JUMP: PCSource=10, PCWrite=1.
- REQ-011: illegal SHALL pulse high for exactly the DECODE cycle when opcode is unsupported; the FSM then returns to FETCH with no register, memory or PC write.
- REQ-012: fetch_count SHALL increment by 1 on each completing FETCH cycle and wrap modulo 2^CNT_W.
- REQ-013: RegWrite, MemWrite and PCWrite SHALL never be high in the same cycle.
- REQ-014: MemWrite SHALL remain asserted for every wait cycle of MEMWRITE; the external memory treats only the mem_ready cycle as the commit.

Reset
- REQ-015: While reset=0, the block SHALL force state=FETCH and fetch_count=0, and every registered output SHALL read 0, independent of clock.
- REQ-016: Reset asserted in any state, including mid-wait, SHALL abort the instruction with no further write strobe.
- REQ-017: The first rising edge after reset release SHALL evaluate FETCH normally.

Structure
- REQ-018: The state encodings, opcode constants and ALUOp codes SHALL live in a shared package/include, mips_defs, also used by the datapath and ALU decoder.
- REQ-019: The block SHALL be one FSM module with no sub-modules; the ALU-control decoder (ALUOp+funct) SHALL remain a separate existing module.

Verification
- REQ-020: The bench SHALL cover: reset release, lw, MEM_HANDSHAKE=0 -> states 0,1,2,3,4,0; RegWrite=1 and MemtoReg=1 in state 4 only; fetch_count=1.
- REQ-021: The bench SHALL cover: sw, MEM_HANDSHAKE=1, mem_ready low 3 cycles in MEMWRITE -> MemWrite high 4 cycles, then FETCH.
- REQ-022: The bench SHALL cover: beq with zero=1 -> PCWrite=1, PCSource=01 in BRANCH; zero=0 -> PCWrite=0.
- REQ-023: The bench SHALL cover: opcode 111111 -> illegal one-cycle pulse, next state FETCH, no write strobes.
- REQ-024: The bench SHALL cover: reset low during a MEMREAD wait -> state=0 immediately, all outputs 0, fetch_count=0.
- REQ-025: The bench SHALL cover: CNT_W=4, 17 j instructions -> fetch_count=1 (wrap).
